// File: rtl/spi_master_mcs_if.sv
// Command/response channel of the multi-chip-select SPI master.
// The block itself connects through the slave modport; the requester uses master.
interface spi_master_mcs_if #(
    parameter int unsigned NCS  = 4,
    parameter int unsigned MAXW = 32,
    parameter int unsigned DIVW = 8
);
    localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int unsigned LW  = $clog2(MAXW);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [CSW-1:0]  cmd_cs;
    logic [LW-1:0]   cmd_len;
    logic [MAXW-1:0] cmd_data;
    logic [DIVW-1:0] cmd_div;
    logic            cmd_cpol;
    logic            cmd_cpha;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [MAXW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_cs, cmd_len, cmd_data, cmd_div, cmd_cpol, cmd_cpha, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_cs, cmd_len, cmd_data, cmd_div, cmd_cpol, cmd_cpha, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_master_mcs.sv
// Multi-chip-select SPI master: one framed transfer per command, per-command length,
// divider and CPOL/CPHA, captured MISO returned on a response channel.
module spi_master_mcs #(
    parameter int unsigned NCS  = 4,
    parameter int unsigned MAXW = 32,
    parameter int unsigned DIVW = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_master_mcs_if.slave bus,
    input  logic           srst_req,
    output logic           spi_sclk,
    output logic [NCS-1:0] spi_csb,
    output logic           spi_sdo,
    input  logic           spi_sdi,
    output logic           spi_srst_n
);
    localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int unsigned LW  = $clog2(MAXW);

    typedef enum logic [2:0] {StInit, StIdle, StSetup, StShift, StHold, StGap, StResp} state_e;

    state_e          state_q, state_d;
    logic [CSW-1:0]  cs_q;
    logic [MAXW-1:0] data_q;
    logic [DIVW-1:0] div_q;
    logic            cpol_q, cpha_q;
    logic [DIVW-1:0] cnt_q, cnt_d, cnt_next;
    logic [LW-1:0]   bit_q, bit_d, bit_dec;
    logic            first_q, first_d;
    logic            sclk_q, sclk_d;
    logic            sdo_q, sdo_d;
    logic [MAXW-1:0] rx_q, rx_d, rx_shift;
    logic            rsp_valid_q, rsp_valid_d;
    logic [NCS-1:0]  csb_q, csb_d;
    logic [1:0]      sdi_sync_q;
    logic            srst_n_q;
    logic            accept, tick, leading, cs_hit;

    assign bus.cmd_ready = (state_q == StIdle) && !rsp_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rx_q;
    assign spi_sclk      = sclk_q;
    assign spi_sdo       = sdo_q;
    assign spi_csb       = csb_q;
    assign spi_srst_n    = srst_n_q;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign tick     = (cnt_q == '0);
    assign cnt_next = tick ? div_q : cnt_q - 1'b1;
    assign leading  = (sclk_q == cpol_q);
    assign bit_dec  = bit_q - 1'b1;
    // Out-of-range selects run the frame blind: zeros are shifted in instead of MISO.
    assign cs_hit   = (32'(cs_q) < NCS);
    assign rx_shift = {rx_q[MAXW-2:0], cs_hit & sdi_sync_q[1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        first_d     = first_q;
        sclk_d      = sclk_q;
        sdo_d       = sdo_q;
        rx_d        = rx_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StInit: state_d = StIdle;
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = bus.cmd_div;
                    bit_d   = bus.cmd_len;
                    first_d = 1'b1;
                    sclk_d  = bus.cmd_cpol;
                    sdo_d   = bus.cmd_data[bus.cmd_len];
                    rx_d    = '0;
                end
            end
            StSetup: begin
                cnt_d = cnt_next;
                if (tick) state_d = StShift;
            end
            StShift: begin
                cnt_d = cnt_next;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (leading) begin
                        first_d = 1'b0;
                        if (!cpha_q) begin
                            rx_d = rx_shift;
                        end else if (!first_q) begin
                            bit_d = bit_dec;
                            sdo_d = data_q[bit_dec];
                        end
                    end else begin
                        if (cpha_q) rx_d = rx_shift;
                        // Trailing edge of bit 0 returns SCLK to idle and closes the frame.
                        if (bit_q == '0) begin
                            state_d = StHold;
                        end else if (!cpha_q) begin
                            bit_d = bit_dec;
                            sdo_d = data_q[bit_dec];
                        end
                    end
                end
            end
            StHold: begin
                cnt_d = cnt_next;
                if (tick) state_d = StGap;
            end
            StGap: begin
                cnt_d = cnt_next;
                if (tick) state_d = StResp;
            end
            StResp: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        csb_d = '1;
        if ((state_q == StSetup || state_q == StShift || state_q == StHold) && cs_hit) begin
            csb_d[cs_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            bit_q       <= '0;
            first_q     <= 1'b0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            rx_q        <= '0;
            rsp_valid_q <= 1'b0;
            csb_q       <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            first_q     <= first_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            rx_q        <= rx_d;
            rsp_valid_q <= rsp_valid_d;
            csb_q       <= csb_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q   <= '0;
            data_q <= '0;
            div_q  <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (accept) begin
            cs_q   <= bus.cmd_cs;
            data_q <= bus.cmd_data;
            div_q  <= bus.cmd_div;
            cpol_q <= bus.cmd_cpol;
            cpha_q <= bus.cmd_cpha;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdi_sync_q <= '0;
            srst_n_q   <= 1'b0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[0], spi_sdi};
            srst_n_q   <= ~srst_req;
        end
    end
endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed plus randomized bench for spi_master_mcs with a bit-level slave/monitor model.
module tb_spi_master_mcs;
    localparam int unsigned NCS  = 3;
    localparam int unsigned MAXW = 32;
    localparam int unsigned DIVW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           srst_req;
    logic           spi_sclk, spi_sdo, spi_sdi, spi_srst_n;
    logic [NCS-1:0] spi_csb;
    int             smode_g;
    logic           sdi_drv;
    int             checks = 0;
    int             failures = 0;

    spi_master_mcs_if #(.NCS(NCS), .MAXW(MAXW), .DIVW(DIVW)) bus ();

    spi_master_mcs #(.NCS(NCS), .MAXW(MAXW), .DIVW(DIVW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .srst_req   (srst_req),
        .spi_sclk   (spi_sclk),
        .spi_csb    (spi_csb),
        .spi_sdo    (spi_sdo),
        .spi_sdi    (spi_sdi),
        .spi_srst_n (spi_srst_n)
    );

    always #5 clk = ~clk;

    // Slave: 0 = loopback, 1 = echo a word MSB first (mode 0), 2 = drive a constant level.
    assign spi_sdi = (smode_g == 0) ? spi_sdo : sdi_drv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int cs, input int len, input logic [31:0] data, input int div,
                        input bit cpol, input bit cpha, input int smode,
                        input logic [31:0] sword, input int hold, input int abort_edge);
        int              h, cyc, edges, sp_bad, low_cnt, first_low, wrong_cs, last_edge, sidx;
        int              stable_bad;
        logic [63:0]     m;
        logic [31:0]     mask, mosi, exp_rx, held;
        logic [NCS-1:0]  exp_csb;
        bit              prev_sclk, lead, done, aborted;
        h = div + 1;
        m = (64'd1 << (len + 1)) - 64'd1;
        mask = m[31:0];
        exp_csb = ~(3'b001 << cs);
        smode_g = smode;
        sdi_drv = (smode == 2) ? 1'b1 : 1'b0;
        bus.rsp_ready = (hold > 0) ? 1'b0 : 1'b1;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_cs   = 2'(cs);
        bus.cmd_len  = 5'(len);
        bus.cmd_data = data;
        bus.cmd_div  = 8'(div);
        bus.cmd_cpol = cpol;
        bus.cmd_cpha = cpha;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("sclk_idle_start", spi_sclk, cpol);
        prev_sclk = cpol;
        edges = 0; sp_bad = 0; low_cnt = 0; first_low = -1; wrong_cs = 0; last_edge = 0;
        mosi = 0; sidx = len; cyc = 0; done = 0; aborted = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                done = 1;
            end else begin
                if (spi_csb !== '1) begin
                    low_cnt++;
                    if (first_low < 0) begin
                        first_low = cyc;
                        if (smode == 1) sdi_drv = sword[len];
                    end
                    if (spi_csb !== exp_csb) wrong_cs++;
                end
                if (spi_sclk !== prev_sclk) begin
                    lead = (prev_sclk == cpol);
                    edges++;
                    if (edges > 1 && cyc - last_edge != h) sp_bad++;
                    last_edge = cyc;
                    if (lead != cpha) mosi = {mosi[30:0], spi_sdo};
                    if (smode == 1 && !lead && sidx > 0) begin
                        sidx--;
                        sdi_drv = sword[sidx];
                    end
                    prev_sclk = spi_sclk;
                    if (abort_edge > 0 && edges == abort_edge) begin
                        rst = 1'b1;
                        aborted = 1;
                        done = 1;
                    end
                end
                if (!done) begin
                    @(posedge clk);
                    cyc++;
                    if (cyc > 3000) done = 1;
                end
            end
        end
        if (aborted) return;
        if (cs >= int'(NCS)) exp_rx = 0;
        else if (smode == 0) exp_rx = data & mask;
        else if (smode == 1) exp_rx = sword & mask;
        else exp_rx = mask;
        chk("rsp_latency", cyc, (2 * len + 5) * h + 1);
        chk("rsp_data", bus.rsp_data, exp_rx);
        chk("sclk_edges", edges, 2 * (len + 1));
        chk("mosi_bits", mosi & mask, data & mask);
        chk("sclk_spacing_bad", sp_bad, 0);
        chk("csb_low_cycles", low_cnt, (cs < int'(NCS)) ? (2 * len + 4) * h : 0);
        chk("csb_wrong_select", wrong_cs, 0);
        if (cs < int'(NCS)) chk("csb_first_low", first_low, 1);
        chk("sclk_idle_end", spi_sclk, cpol);
        if (hold > 0) begin
            held = bus.rsp_data;
            stable_bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.cmd_ready !== 1'b0)
                    stable_bad++;
            end
            chk("rsp_hold_stable_bad", stable_bad, 0);
            chk("rsp_hold_data", bus.rsp_data, exp_rx);
            bus.rsp_ready = 1'b1;
        end else begin
            @(negedge clk);
            chk("rsp_valid_one_cycle", bus.rsp_valid, 0);
            chk("cmd_ready_after_rsp", bus.cmd_ready, 1);
        end
    endtask

    initial begin
        int          nvalid;
        int          len, div, mode, cs;
        logic [31:0] data;
        rst = 1'b1;
        srst_req = 1'b0;
        smode_g = 2;
        sdi_drv = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_cs = '0;
        bus.cmd_len = '0;
        bus.cmd_data = '0;
        bus.cmd_div = '0;
        bus.cmd_cpol = 1'b0;
        bus.cmd_cpha = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_csb", spi_csb, 3'b111);
        chk("rst_sdo", spi_sdo, 0);
        chk("rst_srst_n", spi_srst_n, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", bus.cmd_ready, 1);
        chk("srst_n_idle", spi_srst_n, 1);

        // Soft-reset pin follows the request one clock later.
        @(negedge clk);
        srst_req = 1'b1;
        #1;
        chk("srst_n_not_yet", spi_srst_n, 1);
        @(negedge clk);
        chk("srst_n_low", spi_srst_n, 0);
        srst_req = 1'b0;
        @(negedge clk);
        chk("srst_n_release", spi_srst_n, 1);

        // Mode 0, echoing slave on select 2.
        xfer(2, 7, 32'h0000_00A5, 3, 1'b0, 1'b0, 1, 32'h0000_003C, 0, 0);
        // Modes 1..3 with loopback.
        xfer(0, 15, 32'h0000_1234, 3, 1'b0, 1'b1, 0, 0, 0, 0);
        xfer(1, 15, 32'h0000_1234, 3, 1'b1, 1'b0, 0, 0, 0, 0);
        xfer(2, 15, 32'h0000_1234, 3, 1'b1, 1'b1, 0, 0, 0, 0);
        // Response back-pressure, then an immediate back-to-back command.
        xfer(1, 11, 32'h0000_0ABC, 2, 1'b0, 1'b0, 0, 0, 50, 0);
        xfer(0, 9, 32'h0000_0155, 2, 1'b0, 1'b0, 0, 0, 0, 0);
        // Full width at clk/2; the synchroniser delay rules out loopback at H=1, so MISO
        // is held high and MOSI is checked bit by bit.
        xfer(1, 31, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 2, 0, 0, 0);
        // Unpopulated select: frame runs with every CSB high and RX reads as zero.
        xfer(3, 7, 32'h0000_005A, 2, 1'b0, 1'b0, 0, 0, 0, 0);

        // Reset mid-frame on the leading edge of bit 10 of a 32-bit transfer.
        xfer(0, 31, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 0, 0, 0, 2 * (31 - 10) + 1);
        #1;
        chk("abort_cmd_ready", bus.cmd_ready, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_csb", spi_csb, 3'b111);
        chk("abort_sdo", spi_sdo, 0);
        chk("abort_srst_n", spi_srst_n, 0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) nvalid++;
        end
        chk("abort_no_rsp", nvalid, 0);
        xfer(2, 31, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            len  = $urandom_range(31, 0);
            div  = $urandom_range(4, 2);
            mode = $urandom_range(3, 0);
            cs   = $urandom_range(2, 0);
            data = $urandom;
            xfer(cs, len, data, div, mode[1], mode[0], 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
